cnn_layer_accel_conv_accum: RTL and testbench

- Sits directly downstream of cnn_layer_accel_layer_conv_array and consumes its per-row DSP partial sums (dataout / dataout_valid).
- Each cycle it adds the three lane partial sums together. It then accumulates those sums over a configured number of valid samples (kernel depth × channel passes).
- Each completed result is rounded, right-shifted and saturated to C_CONV_RESULT_WIDTH, then pushed into a small output FIFO with a valid/ready interface.
- It drives pipeline_active back to the conv array so that upstream data stops before the FIFO can overflow.

---
 rtl/cnn_layer_accel_conv_accum.sv | 141 ++++++++++++++
 tb/tb_cnn_layer_accel_conv_accum.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_conv_accum.sv
// Convolution accumulator: sums conv-array lane partials, accumulates over a configured
// depth, rounds/shifts/saturates each result and queues it in a small FWFT output FIFO.
module cnn_layer_accel_conv_accum #(
  parameter int C_MAX_WINDOW_SIZE   = 3,
  parameter int C_DSP_OUTPUT_WIDTH  = 48,
  parameter int C_ACCUM_WIDTH       = 60,
  parameter int C_CONV_RESULT_WIDTH = 16,
  parameter int C_FIFO_DEPTH        = 8,
  parameter int C_STALL_MARGIN      = 4
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             count_init,
  input  logic [9:0]                                       cfg_depth,
  input  logic [5:0]                                       cfg_shift,
  input  logic [C_MAX_WINDOW_SIZE*C_DSP_OUTPUT_WIDTH-1:0]  i_datain,
  input  logic                                             datain_valid,
  output logic signed [C_CONV_RESULT_WIDTH-1:0]            dataout,
  output logic                                             dataout_valid,
  input  logic                                             dataout_ready,
  output logic                                             pipeline_active,
  output logic                                             overflow
);

  localparam int DW  = C_DSP_OUTPUT_WIDTH;
  localparam int AW  = C_ACCUM_WIDTH;
  localparam int R   = C_CONV_RESULT_WIDTH;
  localparam int FAW = $clog2(C_FIFO_DEPTH);

  localparam logic signed [AW:0] SAT_MAX = {{(AW-R+2){1'b0}}, {(R-1){1'b1}}};
  localparam logic signed [AW:0] SAT_MIN = {{(AW-R+2){1'b1}}, {(R-1){1'b0}}};

  // Rounding add is one bit wider than the accumulator so it can never wrap.
  function automatic logic signed [R-1:0] round_sat(input logic signed [AW-1:0] a,
                                                    input logic [5:0] sh);
    logic signed [AW:0] x;
    x = {a[AW-1], a};
    if (sh != 6'd0) begin
      x = x + (((AW+1)'(1)) << (sh - 6'd1));
      x = x >>> sh;
    end
    if (x > SAT_MAX)      x = SAT_MAX;
    else if (x < SAT_MIN) x = SAT_MIN;
    return x[R-1:0];
  endfunction

  logic [9:0]               depth;
  logic [5:0]               shift;
  logic [9:0]               count;
  logic                     last_sample;
  logic signed [DW-1:0]     lane;
  logic signed [AW-1:0]     lane_total;

  logic signed [AW-1:0]     sum_p1;
  logic                     vld_p1;
  logic signed [AW-1:0]     acc_p2;
  logic                     vld_p2;
  logic signed [R-1:0]      res_p3;
  logic                     vld_p3;

  logic signed [R-1:0]      mem [C_FIFO_DEPTH];
  logic [FAW-1:0]           wr_ptr;
  logic [FAW-1:0]           rd_ptr;
  logic [FAW:0]             occ;
  logic [FAW:0]             occ_next;
  logic                     full;
  logic                     pop;
  logic                     push_ok;

  always_comb begin
    lane_total = '0;
    lane       = '0;
    for (int n = 0; n < C_MAX_WINDOW_SIZE; n++) begin
      lane       = i_datain[n*DW +: DW];
      lane_total = lane_total + AW'(lane);
    end
  end

  assign last_sample   = (count == depth - 10'd1);
  assign dataout_valid = (occ != '0);
  assign full          = (occ == (FAW+1)'(C_FIFO_DEPTH));
  assign pop           = dataout_valid && dataout_ready;
  assign push_ok       = vld_p3 && (!full || pop);
  assign dataout       = dataout_valid ? mem[rd_ptr] : '0;

  always_comb begin
    occ_next = occ;
    if (push_ok) occ_next = occ_next + (FAW+1)'(1);
    if (pop)     occ_next = occ_next - (FAW+1)'(1);
  end

  // Control path: configuration, sample counter, stage valids, FIFO pointers and flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      depth           <= 10'd1;
      shift           <= '0;
      count           <= '0;
      vld_p1          <= 1'b0;
      vld_p2          <= 1'b0;
      vld_p3          <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      occ             <= '0;
      pipeline_active <= 1'b1;
      overflow        <= 1'b0;
    end else begin
      if (count_init) begin
        depth <= (cfg_depth == 10'd0) ? 10'd1 : cfg_depth;
        shift <= cfg_shift;
        count <= '0;
      end else if (vld_p1) begin
        count <= last_sample ? 10'd0 : count + 10'd1;
      end
      // stage 1
      vld_p1 <= datain_valid && !count_init;
      // stage 2
      vld_p2 <= vld_p1 && !count_init && last_sample;
      // stage 3
      vld_p3 <= vld_p2 && !count_init;
      // FIFO write
      if (push_ok) wr_ptr <= wr_ptr + FAW'(1);
      if (pop)     rd_ptr <= rd_ptr + FAW'(1);
      occ             <= occ_next;
      pipeline_active <= (occ_next < (FAW+1)'(C_FIFO_DEPTH - C_STALL_MARGIN));
      if (vld_p3 && full && !pop) overflow <= 1'b1;
    end
  end

  // Data path: no reset, qualified by the stage valids.
  always_ff @(posedge clk) begin
    // stage 1
    if (datain_valid) sum_p1 <= lane_total;
    // stage 2: a zero count restarts the accumulation from the incoming sum
    if (vld_p1) acc_p2 <= ((count == 10'd0) ? '0 : acc_p2) + sum_p1;
    // stage 3
    if (vld_p2) res_p3 <= round_sat(acc_p2, shift);
    // FIFO write
    if (push_ok) mem[wr_ptr] <= res_p3;
  end

endmodule

// File: tb/tb_cnn_layer_accel_conv_accum.sv
// Scoreboard bench for cnn_layer_accel_conv_accum: a behavioural model queues expected
// results as samples are issued; a monitor compares every accepted output against it.
module tb_cnn_layer_accel_conv_accum;
  localparam int W  = 3;
  localparam int DW = 48;
  localparam int R  = 16;
  localparam int FD = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 count_init;
  logic [9:0]           cfg_depth;
  logic [5:0]           cfg_shift;
  logic [W*DW-1:0]      i_datain;
  logic                 datain_valid;
  logic signed [R-1:0]  dataout;
  logic                 dataout_valid;
  logic                 dataout_ready;
  logic                 pipeline_active;
  logic                 overflow;

  always #5 clk = ~clk;

  cnn_layer_accel_conv_accum dut (
    .clk(clk), .rst(rst), .count_init(count_init), .cfg_depth(cfg_depth),
    .cfg_shift(cfg_shift), .i_datain(i_datain), .datain_valid(datain_valid),
    .dataout(dataout), .dataout_valid(dataout_valid), .dataout_ready(dataout_ready),
    .pipeline_active(pipeline_active), .overflow(overflow)
  );

  int     checks = 0;
  int     errors = 0;
  longint exp_q[$];
  bit     exp_ovf = 1'b0;
  longint m_acc = 0;
  int     m_cnt = 0;
  int     m_depth = 1;
  int     m_shift = 0;
  bit     rand_ready = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Round half up at the shift point, then clamp to the signed result range.
  function automatic longint ref_result(input longint acc, input int sh);
    longint r;
    if (sh == 0) r = acc;
    else         r = (acc + (longint'(1) << (sh - 1))) >>> sh;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) dataout_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_init(input int d, input int s);
    repeat (3) tick();
    cfg_depth  = 10'(d);
    cfg_shift  = 6'(s);
    count_init = 1'b1;
    tick();
    count_init = 1'b0;
    m_depth = (d == 0) ? 1 : d;
    m_shift = s;
    m_acc   = 0;
    m_cnt   = 0;
  endtask

  task automatic send(input longint a, input longint b, input longint c);
    i_datain     = {c[DW-1:0], b[DW-1:0], a[DW-1:0]};
    datain_valid = 1'b1;
    tick();
    datain_valid = 1'b0;
    m_acc += a + b + c;
    m_cnt++;
    if (m_cnt == m_depth) begin
      if (exp_q.size() >= FD) exp_ovf = 1'b1;
      else                    exp_q.push_back(ref_result(m_acc, m_shift));
      m_acc = 0;
      m_cnt = 0;
    end
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    end
  endtask

  function automatic longint rand_lane();
    logic [63:0] r;
    r = {$urandom, $urandom};
    if ($urandom_range(0, 4) == 0) return $signed(r) >>> 24;
    return longint'($urandom_range(0, 2000)) - 1000;
  endfunction

  // Monitor: every accepted output must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && dataout_valid === 1'b1 && dataout_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0d required=none", dataout);
        end else begin
          check("dataout", dataout, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; count_init = 1'b0; cfg_depth = '0; cfg_shift = '0;
    i_datain = '0; datain_valid = 1'b0; dataout_ready = 1'b1;
    repeat (2) tick();
    check("rst_valid", dataout_valid, 0);
    check("rst_data", dataout, 0);
    check("rst_ovf", overflow, 0);
    check("rst_pa", pipeline_active, 1);
    rst = 1'b1;
    tick();

    // basic sum and latency
    do_init(3, 0);
    send(1, 2, 3);
    send(1, 2, 3);
    send(1, 2, 3);
    check("lat_k0", dataout_valid, 0);
    tick();
    check("lat_k1", dataout_valid, 0);
    tick();
    check("lat_k2", dataout_valid, 0);
    tick();
    check("lat_k3", dataout_valid, 1);
    check("lat_k3_data", dataout, 18);
    wait_empty(20);

    // rounding
    do_init(1, 2);
    send(6, 0, 0);
    send(5, 0, 0);
    send(-6, 0, 0);
    wait_empty(20);

    // saturation
    do_init(1, 0);
    send(40000, 0, 0);
    send(-40000, 0, 0);
    send(32767, 1, 0);
    wait_empty(20);

    // gapped valid then reinit discards the stale partial
    do_init(4, 0);
    send(1, 1, 1);
    send(1, 1, 1);
    repeat (5) tick();
    do_init(2, 0);
    send(2, 2, 2);
    send(2, 2, 2);
    wait_empty(20);
    repeat (6) tick();

    // randomized traffic, issuing only while the accelerator asks for data
    rand_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      do_init($urandom_range(0, 6), $urandom_range(0, 12));
      for (int i = 0; i < 40; i++) begin
        if (pipeline_active && $urandom_range(0, 3) != 0)
          send(rand_lane(), rand_lane(), rand_lane());
        else
          tick();
      end
    end
    rand_ready = 1'b0;
    dataout_ready = 1'b1;
    wait_empty(200);
    check("rand_ovf", overflow, exp_ovf);

    // backpressure: fill, overflow, drain
    dataout_ready = 1'b0;
    do_init(1, 0);
    for (int j = 0; j < 10; j++) begin
      send(j + 1, 0, 0);
      check("pa_fill", pipeline_active, (j < 6) ? 1 : 0);
    end
    repeat (3) tick();
    check("bp_ovf", overflow, exp_ovf);
    check("bp_valid", dataout_valid, 1);
    check("bp_head", dataout, 1);
    check("bp_pa", pipeline_active, 0);
    dataout_ready = 1'b1;
    wait_empty(40);
    repeat (2) tick();
    check("bp_pa_back", pipeline_active, 1);
    check("bp_empty", dataout_valid, 0);

    // reset mid-operation
    dataout_ready = 1'b0;
    do_init(5, 0);
    for (int j = 0; j < 13; j++) send(1, 0, 0);
    repeat (3) tick();
    check("mid_valid", dataout_valid, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    m_acc = 0; m_cnt = 0; m_depth = 1; m_shift = 0;
    check("mid_rst_valid", dataout_valid, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_pa", pipeline_active, 1);
    dataout_ready = 1'b1;
    do_init(5, 0);
    for (int j = 0; j < 5; j++) send(1, 0, 0);
    wait_empty(20);
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
